// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers, TX holding register plus shifter,
// and an RX path that feeds a 4-entry receive FIFO.
module uart_mmio #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  rdop,
  input  logic [1:0]  wrop,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic        Rx_Serial,
  output logic        Tx_Serial
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic w_selTx, w_selRx, w_selCon, w_rdEn, w_wrEn;
  assign w_selTx  = (addr == 32'h4000_0018);
  assign w_selRx  = (addr == 32'h4000_001C);
  assign w_selCon = (addr == 32'h4000_0020);
  assign w_rdEn   = (rdop != 2'b10);
  assign w_wrEn   = (wrop != 2'b10);
  assign hit      = w_selTx | w_selRx | w_selCon;

  logic w_unused;
  assign w_unused = ^wdata[31:8];

  state_t           r_txState, w_txStateNext;
  logic [CNT_W-1:0] r_txCnt, w_txCntNext;
  logic [2:0]       r_txBit, w_txBitNext;
  logic [7:0]       r_txShift, w_txShiftNext;
  logic             r_txSerial, w_txSerialNext;
  logic [7:0]       r_txHold;
  logic             r_txHoldFull;
  logic             w_txLoad, w_txAccept, w_txBusy;

  // STOP reloads straight from the holding register so consecutive frames abut.
  always_comb begin
    w_txStateNext  = r_txState;
    w_txCntNext    = r_txCnt;
    w_txBitNext    = r_txBit;
    w_txShiftNext  = r_txShift;
    w_txSerialNext = r_txSerial;
    w_txLoad       = 1'b0;
    case (r_txState)
      S_IDLE: begin
        w_txSerialNext = 1'b1;
        if (r_txHoldFull) begin
          w_txLoad       = 1'b1;
          w_txShiftNext  = r_txHold;
          w_txCntNext    = '0;
          w_txSerialNext = 1'b0;
          w_txStateNext  = S_START;
        end
      end
      S_START: begin
        if (r_txCnt == BIT_LAST) begin
          w_txCntNext    = '0;
          w_txBitNext    = 3'd0;
          w_txSerialNext = r_txShift[0];
          w_txStateNext  = S_DATA;
        end else begin
          w_txCntNext = r_txCnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (r_txCnt == BIT_LAST) begin
          w_txCntNext = '0;
          if (r_txBit == 3'd7) begin
            w_txSerialNext = 1'b1;
            w_txStateNext  = S_STOP;
          end else begin
            w_txBitNext    = r_txBit + 3'd1;
            w_txShiftNext  = {1'b0, r_txShift[7:1]};
            w_txSerialNext = r_txShift[1];
          end
        end else begin
          w_txCntNext = r_txCnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (r_txCnt == BIT_LAST) begin
          w_txCntNext = '0;
          if (r_txHoldFull) begin
            w_txLoad       = 1'b1;
            w_txShiftNext  = r_txHold;
            w_txSerialNext = 1'b0;
            w_txStateNext  = S_START;
          end else begin
            w_txSerialNext = 1'b1;
            w_txStateNext  = S_IDLE;
          end
        end else begin
          w_txCntNext = r_txCnt + CNT_ONE;
        end
      end
      default: w_txStateNext = S_IDLE;
    endcase
  end

  assign w_txAccept = w_wrEn & w_selTx & (~r_txHoldFull | w_txLoad);
  assign w_txBusy   = (r_txState != S_IDLE);
  assign Tx_Serial  = r_txSerial;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_txState    <= S_IDLE;
      r_txCnt      <= '0;
      r_txBit      <= 3'd0;
      r_txShift    <= 8'd0;
      r_txSerial   <= 1'b1;
      r_txHold     <= 8'd0;
      r_txHoldFull <= 1'b0;
    end else begin
      r_txState  <= w_txStateNext;
      r_txCnt    <= w_txCntNext;
      r_txBit    <= w_txBitNext;
      r_txShift  <= w_txShiftNext;
      r_txSerial <= w_txSerialNext;
      if (w_txAccept) begin
        r_txHold     <= wdata[7:0];
        r_txHoldFull <= 1'b1;
      end else if (w_txLoad) begin
        r_txHoldFull <= 1'b0;
      end
    end
  end

  logic [1:0]       r_rxSync;
  logic             w_rxs;
  state_t           r_rxState, w_rxStateNext;
  logic [CNT_W-1:0] r_rxCnt, w_rxCntNext;
  logic [2:0]       r_rxBit, w_rxBitNext;
  logic [7:0]       r_rxShift, w_rxShiftNext;
  logic             w_rxDone, w_rxFrmErr;

  assign w_rxs = r_rxSync[1];

  // START samples mid-bit; a high level there means the falling edge was a glitch.
  always_comb begin
    w_rxStateNext = r_rxState;
    w_rxCntNext   = r_rxCnt;
    w_rxBitNext   = r_rxBit;
    w_rxShiftNext = r_rxShift;
    w_rxDone      = 1'b0;
    w_rxFrmErr    = 1'b0;
    case (r_rxState)
      S_IDLE: begin
        if (!w_rxs) begin
          w_rxCntNext   = '0;
          w_rxStateNext = S_START;
        end
      end
      S_START: begin
        if (r_rxCnt == HALF_LAST) begin
          w_rxCntNext   = '0;
          w_rxBitNext   = 3'd0;
          w_rxStateNext = w_rxs ? S_IDLE : S_DATA;
        end else begin
          w_rxCntNext = r_rxCnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (r_rxCnt == BIT_LAST) begin
          w_rxCntNext   = '0;
          w_rxShiftNext = {w_rxs, r_rxShift[7:1]};
          if (r_rxBit == 3'd7) w_rxStateNext = S_STOP;
          else                 w_rxBitNext   = r_rxBit + 3'd1;
        end else begin
          w_rxCntNext = r_rxCnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (r_rxCnt == BIT_LAST) begin
          w_rxCntNext   = '0;
          w_rxStateNext = S_IDLE;
          w_rxDone      = w_rxs;
          w_rxFrmErr    = ~w_rxs;
        end else begin
          w_rxCntNext = r_rxCnt + CNT_ONE;
        end
      end
      default: w_rxStateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxSync  <= 2'b11;
      r_rxState <= S_IDLE;
      r_rxCnt   <= '0;
      r_rxBit   <= 3'd0;
      r_rxShift <= 8'd0;
    end else begin
      r_rxSync  <= {r_rxSync[0], Rx_Serial};
      r_rxState <= w_rxStateNext;
      r_rxCnt   <= w_rxCntNext;
      r_rxBit   <= w_rxBitNext;
      r_rxShift <= w_rxShiftNext;
    end
  end

  logic [7:0] r_fifo [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_count;
  logic       r_overrun, r_frmErr;
  logic       w_pop, w_push, w_full, w_overrunSet;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_pop        = w_rdEn & w_selRx & (r_count != 3'd0);
  assign w_full       = (r_count == 3'd4);
  assign w_push       = w_rxDone & (~w_full | w_pop);
  assign w_overrunSet = w_rxDone & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= r_rxShift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp      <= 2'd0;
      r_rp      <= 2'd0;
      r_count   <= 3'd0;
      r_overrun <= 1'b0;
      r_frmErr  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop)  r_rp <= r_rp + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_overrunSet)                        r_overrun <= 1'b1;
      else if (w_wrEn && w_selCon && wdata[3]) r_overrun <= 1'b0;
      if (w_rxFrmErr)                          r_frmErr  <= 1'b1;
      else if (w_wrEn && w_selCon && wdata[4]) r_frmErr  <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (w_rdEn) begin
      if (w_selRx && (r_count != 3'd0)) rdata = {24'd0, r_fifo[r_rp]};
      else if (w_selCon)
        rdata = {27'd0, r_frmErr, r_overrun, (r_count != 3'd0), r_txHoldFull, w_txBusy};
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio at 10 clocks per bit: TX framing, back-to-back
// frames, RX FIFO/overrun, glitch and framing errors, and reset mid-frame.
module tb_uart_mmio;

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [1:0]  rdop = 2'b10;
  logic [1:0]  wrop = 2'b10;
  logic [31:0] rdata;
  logic        hit;
  logic        Rx_Serial = 1'b1;
  logic        Tx_Serial;

  int errors = 0;
  int checks = 0;

  logic txLog [0:511];
  int   logIdx = 0;
  logic logEn = 1'b0;

  uart_mmio #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .rdop(rdop), .wrop(wrop), .rdata(rdata), .hit(hit),
    .Rx_Serial(Rx_Serial), .Tx_Serial(Tx_Serial)
  );

  always #5 clk = ~clk;

  // Records the line level of each cycle; index 0 is the cycle before the triggering edge.
  always @(negedge clk) begin
    if (logEn) begin
      if (logIdx < 512) txLog[logIdx] = Tx_Serial;
      logIdx++;
    end else begin
      logIdx = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic doWrite, input logic doRead, output logic [31:0] rd);
    addr  = a;
    wdata = d;
    wrop  = doWrite ? 2'b00 : 2'b10;
    rdop  = doRead  ? 2'b00 : 2'b10;
    #1;
    rd = rdata;
    tick();
    wrop = 2'b10;
    rdop = 2'b10;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] rd, output logic h);
    addr = a;
    rdop = 2'b00;
    #1;
    rd = rdata;
    h  = hit;
    rdop = 2'b10;
  endtask

  task automatic checkFrameLog(input int start, input logic [7:0] b, input string tag);
    logic [9:0] f;
    int bad;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int c = 0; c < 10; c++)
        if (txLog[start + 10*k + c] !== f[k]) bad++;
      checkOutput($sformatf("%s_bit%0d_wrongCycles", tag, k), bad, 0);
    end
  endtask

  task automatic checkIdleLog(input int first, input int last, input string tag);
    int bad;
    bad = 0;
    for (int i = first; i <= last; i++)
      if (txLog[i] !== 1'b1) bad++;
    checkOutput($sformatf("%s_lowCycles", tag), bad, 0);
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stopBit);
    logic [9:0] f;
    f = {stopBit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      Rx_Serial = f[k];
      repeat (10) tick();
    end
    Rx_Serial = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        h;
    int          lows;

    $display("[TB] reset checks");
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("reset_tx", {31'd0, Tx_Serial}, 32'd1);
    reset = 1'b0;
    tick();
    peek(ADDR_CON, rd, h);
    checkOutput("reset_con", rd, 32'd0);
    checkOutput("con_hit", {31'd0, h}, 32'd1);
    peek(ADDR_RXD, rd, h);
    checkOutput("reset_rxd", rd, 32'd0);
    peek(32'h4000_000C, rd, h);
    checkOutput("miss_hit", {31'd0, h}, 32'd0);
    addr = ADDR_CON;
    #1;
    checkOutput("noread_rdata", rdata, 32'd0);

    $display("[TB] single TX frame");
    logEn = 1'b1;
    applyStimulus(ADDR_TXD, 32'hFFFF_FFA5, 1'b1, 1'b0, rd);
    tick();
    peek(ADDR_CON, rd, h);
    checkOutput("tx1_busy_first", rd, 32'h1);
    repeat (99) tick();
    peek(ADDR_CON, rd, h);
    checkOutput("tx1_busy_last", rd, 32'h1);
    tick();
    peek(ADDR_CON, rd, h);
    checkOutput("tx1_done_con", rd, 32'h0);
    repeat (5) tick();
    logEn = 1'b0;
    checkIdleLog(0, 1, "tx1_pre");
    checkFrameLog(2, 8'hA5, "tx1");
    checkIdleLog(102, 106, "tx1_post");

    $display("[TB] back-to-back TX");
    tick();
    logEn = 1'b1;
    applyStimulus(ADDR_TXD, 32'h55, 1'b1, 1'b0, rd);
    repeat (3) tick();
    applyStimulus(ADDR_TXD, 32'h0F, 1'b1, 1'b0, rd);
    peek(ADDR_CON, rd, h);
    checkOutput("b2b_con_full", rd, 32'h3);
    applyStimulus(ADDR_TXD, 32'h33, 1'b1, 1'b0, rd);
    peek(ADDR_CON, rd, h);
    checkOutput("b2b_con_still_full", rd, 32'h3);
    repeat (195) tick();
    peek(ADDR_CON, rd, h);
    checkOutput("b2b_busy_last", rd, 32'h1);
    tick();
    peek(ADDR_CON, rd, h);
    checkOutput("b2b_done_con", rd, 32'h0);
    repeat (30) tick();
    logEn = 1'b0;
    checkFrameLog(2, 8'h55, "b2b_f1");
    checkFrameLog(102, 8'h0F, "b2b_f2");
    checkIdleLog(202, 230, "b2b_no_third");

    $display("[TB] RX five bytes with overrun");
    for (int i = 1; i <= 5; i++) sendRx(8'(i), 1'b1);
    repeat (3) tick();
    peek(ADDR_CON, rd, h);
    checkOutput("rx_con_overrun", rd, 32'h0C);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(ADDR_RXD, 32'd0, 1'b0, 1'b1, rd);
      checkOutput($sformatf("rx_read%0d", i), rd, 32'(i));
    end
    peek(ADDR_CON, rd, h);
    checkOutput("rx_con_empty", rd, 32'h08);
    applyStimulus(ADDR_RXD, 32'd0, 1'b0, 1'b1, rd);
    checkOutput("rx_read_empty", rd, 32'h0);
    applyStimulus(ADDR_CON, 32'h08, 1'b1, 1'b0, rd);
    peek(ADDR_CON, rd, h);
    checkOutput("rx_con_cleared", rd, 32'h0);

    $display("[TB] RX glitch and framing error");
    Rx_Serial = 1'b0;
    repeat (3) tick();
    Rx_Serial = 1'b1;
    repeat (30) tick();
    peek(ADDR_CON, rd, h);
    checkOutput("glitch_con", rd, 32'h0);
    sendRx(8'h5A, 1'b0);
    repeat (15) tick();
    peek(ADDR_CON, rd, h);
    checkOutput("frm_err_con", rd, 32'h10);
    peek(ADDR_RXD, rd, h);
    checkOutput("frm_err_rxd", rd, 32'h0);
    applyStimulus(ADDR_CON, 32'h10, 1'b1, 1'b0, rd);
    peek(ADDR_CON, rd, h);
    checkOutput("frm_err_cleared", rd, 32'h0);

    $display("[TB] reset mid-TX");
    applyStimulus(ADDR_TXD, 32'h81, 1'b1, 1'b0, rd);
    repeat (40) tick();
    checkOutput("midtx_line_low", {31'd0, Tx_Serial}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midtx_tx_after_reset", {31'd0, Tx_Serial}, 32'd1);
    peek(ADDR_CON, rd, h);
    checkOutput("midtx_con", rd, 32'h0);
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (Tx_Serial !== 1'b1) lows++;
    end
    checkOutput("midtx_no_restart_lowCycles", lows, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
